mem_bus_master: RTL and testbench

//  CPU-side memory access unit: consumes the 16-bit address pair and 8-bit data driven by the register

---
 rtl/mem_bus_master.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side byte/wide memory access unit with req/ack bus.
// Optional bus timeout abort enabled by defining BUS_TIMEOUT_EN.
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdat,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_wide,
    output logic        o_busy,
    output logic [7:0]  o_dat,
    output logic        o_load,
    output logic        o_load_hi,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_dat,
    input  logic [7:0]  i_bus_dat,
    output logic        o_bus_we,
    output logic        o_bus_stb,
    input  logic        i_bus_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic        wide_q, wide_d;
    logic        load_q, load_d;
    logic        load_hi_q, load_hi_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        timeout;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count stb-high cycles without ack; cleared while idle and on ack.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && !i_bus_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        dat_d     = dat_q;
        we_d      = we_q;
        wide_d    = wide_q;
        load_d    = 1'b0;
        load_hi_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_wr || i_rd) begin
                    state_d = XFER0;
                    addr_d  = i_addr;
                    wdat_d  = i_wdat;
                    we_d    = i_wr;
                    wide_d  = i_wide && !i_wr;
                end
            end
            XFER0: begin
                if (i_bus_ack) begin
                    if (!we_q) begin
                        dat_d  = i_bus_dat;
                        load_d = 1'b1;
                    end
                    if (wide_q) begin
                        state_d = XFER1;
                        addr_d  = addr_q + 16'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            XFER1: begin
                if (i_bus_ack) begin
                    dat_d     = i_bus_dat;
                    load_d    = 1'b1;
                    load_hi_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdat_q    <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            wide_q    <= 1'b0;
            load_q    <= 1'b0;
            load_hi_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            wide_q    <= wide_d;
            load_q    <= load_d;
            load_hi_q <= load_hi_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Strobe follows state so an async reset drops it immediately.
    assign o_busy     = (state_q != IDLE);
    assign o_bus_stb  = (state_q != IDLE);
    assign o_bus_addr = addr_q;
    assign o_bus_dat  = wdat_q;
    assign o_bus_we   = we_q;
    assign o_dat      = dat_q;
    assign o_load     = load_q;
    assign o_load_hi  = load_hi_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: random ops vs a byte-array model.
// Honours BUS_TIMEOUT_EN the same way as the design.
module tb_mem_bus_master;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_addr = '0;
    logic [7:0]  i_wdat = '0;
    logic        i_rd = 1'b0;
    logic        i_wr = 1'b0;
    logic        i_wide = 1'b0;
    logic        o_busy;
    logic [7:0]  o_dat;
    logic        o_load;
    logic        o_load_hi;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_bus_addr;
    logic [7:0]  o_bus_dat;
    logic [7:0]  i_bus_dat = '0;
    logic        o_bus_we;
    logic        o_bus_stb;
    logic        i_bus_ack = 1'b0;

    mem_bus_master #(.TIMEOUT_CYCLES(15)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_addr(i_addr), .i_wdat(i_wdat),
        .i_rd(i_rd), .i_wr(i_wr), .i_wide(i_wide),
        .o_busy(o_busy), .o_dat(o_dat),
        .o_load(o_load), .o_load_hi(o_load_hi),
        .o_done(o_done), .o_err(o_err),
        .o_bus_addr(o_bus_addr), .o_bus_dat(o_bus_dat),
        .i_bus_dat(i_bus_dat), .o_bus_we(o_bus_we),
        .o_bus_stb(o_bus_stb), .i_bus_ack(i_bus_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] addr;
        bit          we;
        logic [7:0]  dat;
    } txn_t;

    typedef struct {
        bit         is_done;
        logic [7:0] dat;
        bit         hi;
        bit         err;
    } exp_t;

    txn_t txq[$];
    exp_t expq[$];

    logic [7:0] bus_mem [65536];
    logic [7:0] ref_mem [65536];

    int  checks = 0;
    int  failures = 0;
    bit  hold = 1'b0;
    bit  fast = 1'b1;
    bit  pulse_en = 1'b0;
    int  dly = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory responder: acks after a random delay, checks each transfer.
    always @(negedge i_clk) begin
        i_bus_ack = 1'b0;
        i_bus_dat = 8'($urandom);
        if (!i_reset && o_bus_stb && !hold) begin
            if (dly == 0) begin
                chk("bus_txn_expected", 32'(txq.size() != 0), 1);
                if (txq.size() != 0) begin
                    txn_t t;
                    t = txq.pop_front();
                    chk("bus_addr", 32'(o_bus_addr), 32'(t.addr));
                    chk("bus_we", 32'(o_bus_we), 32'(t.we));
                    if (t.we) chk("bus_wdat", 32'(o_bus_dat), 32'(t.dat));
                end
                if (o_bus_we) bus_mem[o_bus_addr] = o_bus_dat;
                else i_bus_dat = bus_mem[o_bus_addr];
                i_bus_ack = 1'b1;
                dly = fast ? 0 : int'($urandom_range(0, 3));
            end else begin
                dly--;
            end
        end
    end

    // Output monitor: pops expected loads/dones in order.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_load) begin
                chk("load_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("load_kind", 32'(e.is_done), 0);
                    chk("load_dat", 32'(o_dat), 32'(e.dat));
                    chk("load_hi", 32'(o_load_hi), 32'(e.hi));
                end
            end
            if (o_done) begin
                chk("done_expected", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_kind", 32'(e.is_done), 1);
                    chk("done_err", 32'(o_err), 32'(e.err));
                end
            end
            if (o_err && !o_done) chk("err_without_done", 1, 0);
        end
    end

    // Issue one access from a negedge; returns at the negedge showing o_done.
    task automatic do_op(input bit rd, input bit wr, input bit wide,
                         input logic [15:0] addr,
                         input logic [7:0] wdat, input int lat);
        int cyc;
        bit seen;
        if (wr) begin
            txq.push_back('{addr, 1'b1, wdat});
            ref_mem[addr] = wdat;
            expq.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
        end else if (rd) begin
            logic [15:0] a1;
            a1 = addr + 16'd1;
            txq.push_back('{addr, 1'b0, 8'h00});
            expq.push_back('{1'b0, ref_mem[addr], 1'b0, 1'b0});
            if (wide) begin
                txq.push_back('{a1, 1'b0, 8'h00});
                expq.push_back('{1'b0, ref_mem[a1], 1'b1, 1'b0});
            end
            expq.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
        end
        i_rd = rd; i_wr = wr; i_wide = wide;
        i_addr = addr; i_wdat = wdat;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            if (o_done) begin
                seen = 1'b1;
                i_rd = 1'b0; i_wr = 1'b0;
            end else if (pulse_en && o_busy) begin
                i_rd = ($urandom_range(0, 1) == 1);
                i_wr = ($urandom_range(0, 3) == 0);
                i_addr = 16'($urandom);
            end else begin
                i_rd = 1'b0; i_wr = 1'b0;
            end
        end
        chk("op_done_seen", 32'(seen), 1);
        if (lat > 0) chk("op_latency", cyc, lat);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_stb", 32'(o_bus_stb), 0);
        chk("rst_dat", 32'(o_dat), 0);
        chk("rst_bus_addr", 32'(o_bus_addr), 0);
        chk("rst_bus_dat", 32'(o_bus_dat), 0);
        chk("rst_strobes", 32'({o_load, o_load_hi, o_done, o_err, o_bus_we}), 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        bus_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        do_op(1, 0, 0, 16'h1234, 8'h00, 2);
        do_op(0, 1, 1, 16'h8000, 8'h5A, 2);
        bus_mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
        bus_mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;
        do_op(1, 0, 1, 16'hFFFF, 8'h00, 3);
        do_op(1, 0, 1, 16'h7FFF, 8'h00, 3);
        do_op(1, 0, 0, 16'h8000, 8'h00, 2);

        fast = 1'b0;
        for (int n = 0; n < 200; n++) begin
            bit wr, wide;
            logic [15:0] a;
            wr = ($urandom_range(0, 2) == 0);
            wide = $urandom_range(0, 1) == 1;
            a = (n % 5 == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                             : 16'($urandom_range(0, 63));
            do_op(!wr, wr, wide, a, 8'($urandom), 0);
            if ($urandom_range(0, 3) == 0) @(negedge i_clk);
        end

        pulse_en = 1'b1;
        do_op(1, 1, 1, 16'h0042, 8'hC3, 0);
        for (int n = 0; n < 20; n++) begin
            do_op(1, 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 63)), 8'h00, 0);
        end
        pulse_en = 1'b0;
        do_op(1, 0, 0, 16'h0042, 8'h00, 0);
        repeat (2) @(negedge i_clk);

        hold = 1'b1;
        i_rd = 1'b1; i_addr = 16'h0300;
        @(negedge i_clk);
        i_rd = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("hold_stb_high", 32'(o_bus_stb), 1);
        #2 i_reset = 1'b1;
        #1;
        chk("async_rst_stb", 32'(o_bus_stb), 0);
        chk("async_rst_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        hold = 1'b0;
        dly = 0;
        repeat (8) @(negedge i_clk);
        chk("post_rst_idle", 32'(o_busy), 0);

        hold = 1'b1;
`ifdef BUS_TIMEOUT_EN
        begin
            int stbc;
            bit got;
            expq.push_back('{1'b1, 8'h00, 1'b0, 1'b1});
            i_rd = 1'b1; i_addr = 16'h0310;
            stbc = 0;
            got = 1'b0;
            @(negedge i_clk);
            i_rd = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                if (o_done) got = 1'b1;
                else begin
                    if (o_bus_stb) stbc++;
                    @(negedge i_clk);
                end
            end
            chk("timeout_done", 32'(got), 1);
            chk("timeout_stb_cycles", stbc, 15);
        end
`else
        i_rd = 1'b1; i_addr = 16'h0310;
        @(negedge i_clk);
        i_rd = 1'b0;
        repeat (40) @(negedge i_clk);
        chk("no_timeout_stb_held", 32'(o_bus_stb), 1);
        #2 i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
`endif
        hold = 1'b0;
        dly = 0;
        repeat (3) @(negedge i_clk);
        do_op(1, 0, 0, 16'h1234, 8'h00, 0);
        repeat (3) @(negedge i_clk);
        chk("txq_drained", txq.size(), 0);
        chk("expq_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
